// File: rtl/app_start_initiator.sv
// app_start_initiator
//   Issues bursts of start requests to an application. A host command gives
//   the number of jobs. The block raises start_valid once per job. It then
//   waits for the application's app_done pulse before it issues the next start.
//   Optional build macro: APP_START_TIMEOUT_EN adds a watchdog on WAIT_DONE.
//   The watchdog raises err after TIMEOUT_CYCLES cycles without app_done.
module app_start_initiator #(
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             cmd_ready,
  output logic             start_valid,
  input  logic             start_ready,
  input  logic             app_done,
  output logic [CNT_W-1:0] done_cnt,
  output logic             busy,
  output logic             burst_done,
  output logic             err,
  input  logic             err_clr
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    ERROR     = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] done_cnt_reg, done_cnt_next;
  logic             start_valid_reg, start_valid_next;
  logic             burst_done_reg, burst_done_next;
  logic             err_reg, err_next;
  logic             timeout_hit;

`ifdef APP_START_TIMEOUT_EN
  // Counter width holds 0..TIMEOUT_CYCLES without overflow.
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] timer_reg, timer_next;

  // The last WAIT_DONE cycle of the allowed window ends without app_done.
  assign timeout_hit = (timer_reg == TMR_LAST);

  // The count restarts at zero on every WAIT_DONE entry.
  // It grows while the FSM stays in WAIT_DONE.
  always_comb begin
    timer_next = '0;
    if (state_reg == WAIT_DONE && state_next == WAIT_DONE)
      timer_next = timer_reg + TMR_W'(1);
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) timer_reg <= '0;
    else        timer_reg <= timer_next;
  end
`else
  // No watchdog: WAIT_DONE waits for app_done indefinitely.
  assign timeout_hit = 1'b0;

  // TIMEOUT_CYCLES has no effect in this build.
  // This empty block only marks the parameter as used.
  if (TIMEOUT_CYCLES > 0) begin : g_no_timeout
  end
`endif

  // In this design err is only set together with a move to ERROR.
  assign cmd_ready   = (state_reg == IDLE) && !err_reg;
  assign start_valid = start_valid_reg;
  assign busy        = (state_reg != IDLE);
  assign burst_done  = burst_done_reg;
  assign err         = err_reg;
  assign done_cnt    = done_cnt_reg;

  // Next-state and next-output decode.
  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    done_cnt_next   = done_cnt_reg;
    err_next        = err_reg;
    burst_done_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (app_done) begin
          // No job is outstanding, so a completion here is a protocol error.
          err_next   = 1'b1;
          state_next = ERROR;
        end else if (cmd_valid && cmd_ready) begin
          done_cnt_next = '0;
          if (cmd_count == '0) begin
            burst_done_next = 1'b1;
          end else begin
            count_next = cmd_count;
            state_next = ISSUE;
          end
        end
      end

      ISSUE: begin
        // This branch also covers app_done that arrives with the handshake.
        // No job is outstanding at that point.
        if (app_done) begin
          err_next   = 1'b1;
          state_next = ERROR;
        end else if (start_valid_reg && start_ready) begin
          state_next = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (app_done) begin
          done_cnt_next = done_cnt_reg + CNT_W'(1);
          // count_reg >= 1, so the counter stops at the latched count.
          // It never wraps, even at the maximum count.
          if (done_cnt_next == count_reg) begin
            burst_done_next = 1'b1;
            state_next      = IDLE;
          end else begin
            state_next = ISSUE;
          end
        end else if (timeout_hit) begin
          err_next   = 1'b1;
          state_next = ERROR;
        end
      end

      ERROR: begin
        if (err_clr) begin
          err_next   = 1'b0;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    // start_valid is registered. It is high in every ISSUE cycle.
    // So it appears one cycle after an accepted command or app_done.
    // It stays up until the handshake moves the FSM out of ISSUE.
    start_valid_next = (state_next == ISSUE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      done_cnt_reg    <= '0;
      start_valid_reg <= 1'b0;
      burst_done_reg  <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      done_cnt_reg    <= done_cnt_next;
      start_valid_reg <= start_valid_next;
      burst_done_reg  <= burst_done_next;
      err_reg         <= err_next;
    end
  end

endmodule

// File: doc/app_start_initiator.md
APP_START_INITIATOR -- requirements
Module: app_start_initiator

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the job-count and completion-count fields.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the maximum number of cycles from accepted start to done.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: host requests a burst of starts.
REQ-006 The block SHALL have port cmd_count, input, CNT_W bits: number of starts in the burst; 0 means none.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit: a command is accepted when cmd_valid and cmd_ready are both high.
REQ-008 The block SHALL have port start_valid, output, 1 bit: start request to the application (ctrl_t.start_valid).
REQ-009 The block SHALL have port start_ready, input, 1 bit: application can accept a start (flags_t.start_ready).
REQ-010 The block SHALL have port app_done, input, 1 bit: one-cycle pulse when the application finishes a job.
REQ-011 The block SHALL have port done_cnt, output, CNT_W bits: jobs completed in the current burst.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 The block SHALL have port burst_done, output, 1 bit: one-cycle pulse when a burst completes.
REQ-014 The block SHALL have port err, output, 1 bit: sticky timeout or protocol error flag.
REQ-015 The block SHALL have port err_clr, input, 1 bit: clears err and leaves ERROR.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT_DONE and ERROR.
REQ-017 cmd_ready SHALL be high only in IDLE while err is 0.
REQ-018 IDLE: an accepted command with cmd_count = 0 SHALL stay in IDLE, clear done_cnt and pulse burst_done on the next cycle.
REQ-019 IDLE: an accepted command with cmd_count > 0 SHALL latch the count, clear done_cnt and go to ISSUE.
REQ-020 ISSUE: start_valid SHALL be 1, registered; once raised, it SHALL not drop before start_ready is sampled high.
REQ-021 ISSUE: a start handshake (start_valid and start_ready both high) SHALL move the FSM to WAIT_DONE on the next cycle, with start_valid low in that cycle.
REQ-022 WAIT_DONE: app_done SHALL increment done_cnt; if the new done_cnt equals the latched count, the FSM SHALL go to IDLE and pulse burst_done, otherwise it SHALL go to ISSUE.
REQ-023 app_done arriving in IDLE or ISSUE SHALL be a protocol error: set err and go to ERROR.
REQ-024 app_done in the same cycle as the start handshake SHALL be treated as a protocol error.
REQ-025 done_cnt SHALL not wrap; a maximum count of 2^CNT_W-1 SHALL complete normally.
REQ-026 ERROR: start_valid SHALL be 0 and busy SHALL be 1; err_clr SHALL clear err and return the FSM to IDLE on the next cycle.
REQ-027 The latency from command acceptance to the first start_valid SHALL be 1 cycle.
REQ-028 The latency from app_done to the next start_valid SHALL be 1 cycle.

Reset
REQ-029 While rst_n is low at a clock edge, the FSM SHALL enter IDLE.
REQ-030 While rst_n is low, start_valid, busy, burst_done and err SHALL be 0, done_cnt SHALL be 0, and the latched count and timeout counter SHALL be 0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst with no burst_done, and start_valid SHALL be 0 in the first post-reset cycle.

Configuration
REQ-032 Macro APP_START_TIMEOUT_EN SHALL enable a timeout watchdog.
REQ-033 With APP_START_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT_DONE and increment each WAIT_DONE cycle; reaching TIMEOUT_CYCLES without app_done SHALL set err and enter ERROR.
REQ-034 With APP_START_TIMEOUT_EN undefined, no counter logic SHALL exist and WAIT_DONE SHALL wait indefinitely.

Verification
REQ-035 cmd_count=3, start_ready always high, app_done 5 cycles after each start -> 3 start handshakes, done_cnt goes 1,2,3, one burst_done pulse, then IDLE.
REQ-036 cmd_count=1, start_ready held low for 10 cycles -> start_valid stays high all 10 cycles; handshake on cycle 11; WAIT_DONE follows.
REQ-037 cmd_count=0 -> no start_valid, burst_done pulses 1 cycle after acceptance, done_cnt=0.
REQ-038 app_done pulsed in IDLE -> err=1, cmd_ready=0; err_clr -> err=0 and IDLE the next cycle.
REQ-039 APP_START_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, app_done never arrives -> err=1 exactly 16 cycles after WAIT_DONE entry; macro undefined -> busy stays 1, err stays 0.
REQ-040 rst_n low for 1 cycle during WAIT_DONE of a cmd_count=4 burst -> IDLE, all outputs 0, no burst_done pulse.
